// File: rtl/flash_arbiter.sv
// Shares the QSPI flash ROM reader between the CPU ROM window and the sound sample fetcher.
// The CPU has priority, the sound port is protected by a starvation limit, and every transfer has a timeout.
module flash_arbiter #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TMO_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_stb,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              snd_stb,
    input  logic [ADDR_W-1:0] snd_addr,
    output logic              snd_ack,
    output logic              snd_err,
    output logic [DATA_W-1:0] snd_data,
    output logic              rom_stb,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic              grant_snd
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_DONE   = 3'd2,
        S_ABORT1 = 3'd3,
        S_ABORT2 = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [TMO_W-1:0]  tmo_inc;
    logic              rom_stb_q, rom_stb_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              grant_snd_q, grant_snd_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_err_q, cpu_err_d;
    logic              snd_ack_q, snd_ack_d;
    logic              snd_err_q, snd_err_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
    logic [DATA_W-1:0] snd_data_q, snd_data_d;
    logic              starve_hit;
    logic              snd_wins;
    logic              tmo_expired;

    assign starve_hit  = (starve_q == STARVE_LIM);
    assign snd_wins    = snd_stb && (!cpu_stb || starve_hit);
    assign tmo_inc     = tmo_q + TMO_W'(1);
    // Expires on the (2**TMO_W-1)th GRANT cycle, i.e. when the counter would reach all-ones.
    assign tmo_expired = (tmo_inc == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            rom_stb_q   <= 1'b0;
            rom_addr_q  <= '0;
            grant_snd_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            snd_ack_q   <= 1'b0;
            snd_err_q   <= 1'b0;
            cpu_data_q  <= '0;
            snd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            rom_stb_q   <= rom_stb_d;
            rom_addr_q  <= rom_addr_d;
            grant_snd_q <= grant_snd_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            snd_ack_q   <= snd_ack_d;
            snd_err_q   <= snd_err_d;
            cpu_data_q  <= cpu_data_d;
            snd_data_q  <= snd_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        rom_stb_d   = rom_stb_q;
        rom_addr_d  = rom_addr_q;
        grant_snd_d = grant_snd_q;
        cpu_data_d  = cpu_data_q;
        snd_data_d  = snd_data_q;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        snd_ack_d   = 1'b0;
        snd_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (snd_wins) begin
                    grant_snd_d = 1'b1;
                    starve_d    = '0;
                    rom_addr_d  = snd_addr;
                    rom_stb_d   = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_GRANT;
                end else if (cpu_stb) begin
                    grant_snd_d = 1'b0;
                    // Count only CPU grants taken while the sound port is waiting.
                    if (!snd_stb) begin
                        starve_d = '0;
                    end else if (!starve_hit) begin
                        starve_d = starve_q + SW'(1);
                    end
                    rom_addr_d  = cpu_addr;
                    rom_stb_d   = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_GRANT;
                end
            end

            S_GRANT: begin
                tmo_d = tmo_inc;
                if (rom_ack) begin
                    rom_stb_d   = 1'b0;
                    grant_snd_d = 1'b0;
                    state_d     = S_DONE;
                    if (grant_snd_q) begin
                        snd_data_d = rom_data;
                        snd_ack_d  = 1'b1;
                    end else begin
                        cpu_data_d = rom_data;
                        cpu_ack_d  = 1'b1;
                    end
                end else if (tmo_expired) begin
                    rom_stb_d   = 1'b0;
                    grant_snd_d = 1'b0;
                    state_d     = S_ABORT1;
                    if (grant_snd_q) begin
                        snd_err_d = 1'b1;
                    end else begin
                        cpu_err_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            // Two idle cycles so the reader is guaranteed to see its strobe drop.
            S_ABORT1: begin
                state_d = S_ABORT2;
            end

            S_ABORT2: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_stb   = rom_stb_q;
    assign rom_addr  = rom_addr_q;
    assign grant_snd = grant_snd_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_data  = cpu_data_q;
    assign snd_ack   = snd_ack_q;
    assign snd_err   = snd_err_q;
    assign snd_data  = snd_data_q;

    a_one_completion: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({cpu_ack_q, cpu_err_q, snd_ack_q, snd_err_q}));

    a_stb_in_grant: assert property (@(posedge clk) disable iff (!rst)
        rom_stb_q == (state_q == S_GRANT));

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration, data routing and latency rules.
module tb_flash_arbiter;

    localparam int ADDR_W     = 22;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TMO_W      = 10;
    localparam int TMO_CYC    = (1 << TMO_W) - 1;

    logic              clk;
    logic              rst;
    logic              cpu_stb;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic              cpu_err;
    logic [DATA_W-1:0] cpu_data;
    logic              snd_stb;
    logic [ADDR_W-1:0] snd_addr;
    logic              snd_ack;
    logic              snd_err;
    logic [DATA_W-1:0] snd_data;
    logic              rom_stb;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [DATA_W-1:0] rom_data;
    logic              grant_snd;

    int checks = 0;
    int passes = 0;

    flash_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_stb(cpu_stb), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_data(cpu_data),
        .snd_stb(snd_stb), .snd_addr(snd_addr), .snd_ack(snd_ack), .snd_err(snd_err), .snd_data(snd_data),
        .rom_stb(rom_stb), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .grant_snd(grant_snd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of the modelled flash: a fixed scramble of the longword address.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic idle_inputs();
        cpu_stb  = 1'b0;
        snd_stb  = 1'b0;
        cpu_addr = '0;
        snd_addr = '0;
        rom_ack  = 1'b0;
        rom_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rom_stb(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rom_stb === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cpu_stb = 1'b1;
        snd_stb = 1'b1;
        rom_ack = 1'b1;
        cpu_addr = 22'h3FFFFF;
        snd_addr = 22'h2AAAAA;
        repeat (3) @(negedge clk);
        checks++; if ({rom_stb, grant_snd} !== 2'b00) $display("FAIL reset_stb_grant got=%b exp=00", {rom_stb, grant_snd}); else passes++;
        checks++; if ({cpu_ack, cpu_err, snd_ack, snd_err} !== 4'b0) $display("FAIL reset_ack_err got=%b exp=0000", {cpu_ack, cpu_err, snd_ack, snd_err}); else passes++;
        checks++; if (rom_addr !== '0) $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); else passes++;
        checks++; if ({cpu_data, snd_data} !== '0) $display("FAIL reset_data got=%h exp=0", {cpu_data, snd_data}); else passes++;
        $display("reset: outputs sampled while rst low");
    endtask

    task automatic test_single_cpu();
        bit ok;
        bit held;
        do_reset();
        cpu_addr = 22'h040010;
        cpu_stb  = 1'b1;
        wait_rom_stb(8, ok);
        checks++; if (!ok) $display("FAIL t1_grant got=no_rom_stb exp=rom_stb"); else passes++;
        checks++; if (rom_addr !== 22'h040010) $display("FAIL t1_rom_addr got=%h exp=040010", rom_addr); else passes++;
        held = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rom_stb !== 1'b1 || cpu_ack !== 1'b0) held = 1'b0;
        end
        checks++; if (!held) $display("FAIL t1_stb_held got=dropped exp=held"); else passes++;
        rom_ack  = 1'b1;
        rom_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rom_ack  = 1'b0;
        rom_data = $urandom;
        checks++; if ({cpu_ack, cpu_err, snd_ack, rom_stb} !== 4'b1000) $display("FAIL t1_ack got=%b exp=1000", {cpu_ack, cpu_err, snd_ack, rom_stb}); else passes++;
        checks++; if (cpu_data !== 32'hDEAD_BEEF) $display("FAIL t1_cpu_data got=%h exp=deadbeef", cpu_data); else passes++;
        checks++; if (snd_data !== '0) $display("FAIL t1_snd_data got=%h exp=0", snd_data); else passes++;
        cpu_stb = 1'b0;
        $display("xfer cpu addr=%h data=%h", cpu_addr, cpu_data);
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0) $display("FAIL t1_ack_pulse got=%b exp=0", cpu_ack); else passes++;
        checks++; if (cpu_data !== 32'hDEAD_BEEF) $display("FAIL t1_data_hold got=%h exp=deadbeef", cpu_data); else passes++;
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [DATA_W-1:0] d1, d2;
        do_reset();
        cpu_addr = ADDR_W'($urandom);
        snd_addr = cpu_addr ^ 22'h155555;
        cpu_stb  = 1'b1;
        snd_stb  = 1'b1;
        wait_rom_stb(8, ok);
        checks++; if (!ok || grant_snd !== 1'b0) $display("FAIL t2_cpu_first got=%b exp=0", grant_snd); else passes++;
        checks++; if (rom_addr !== cpu_addr) $display("FAIL t2_cpu_addr got=%h exp=%h", rom_addr, cpu_addr); else passes++;
        d1 = $urandom;
        rom_ack = 1'b1; rom_data = d1;
        @(negedge clk);
        rom_ack = 1'b0;
        checks++; if ({cpu_ack, snd_ack} !== 2'b10 || cpu_data !== d1) $display("FAIL t2_cpu_ack got=%b/%h exp=10/%h", {cpu_ack, snd_ack}, cpu_data, d1); else passes++;
        $display("xfer cpu addr=%h data=%h", cpu_addr, cpu_data);
        cpu_stb = 1'b0;
        wait_rom_stb(8, ok);
        checks++; if (!ok || grant_snd !== 1'b1) $display("FAIL t2_snd_next got=%b exp=1", grant_snd); else passes++;
        checks++; if (rom_addr !== snd_addr) $display("FAIL t2_snd_addr got=%h exp=%h", rom_addr, snd_addr); else passes++;
        d2 = $urandom;
        rom_ack = 1'b1; rom_data = d2;
        @(negedge clk);
        rom_ack = 1'b0;
        checks++; if ({cpu_ack, snd_ack, grant_snd} !== 3'b010 || snd_data !== d2) $display("FAIL t2_snd_ack got=%b/%h exp=010/%h", {cpu_ack, snd_ack, grant_snd}, snd_data, d2); else passes++;
        checks++; if (cpu_data !== d1) $display("FAIL t2_cpu_data_kept got=%h exp=%h", cpu_data, d1); else passes++;
        $display("xfer snd addr=%h data=%h", snd_addr, snd_data);
        snd_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        bit ok;
        bit exp_snd;
        logic [DATA_W-1:0] d;
        do_reset();
        cpu_addr = ADDR_W'($urandom);
        snd_addr = ~cpu_addr;
        cpu_stb  = 1'b1;
        snd_stb  = 1'b1;
        // Both requesters stay asserted, so each completion immediately re-requests.
        for (int i = 0; i < 2 * (STARVE_MAX + 1); i++) begin
            exp_snd = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
            wait_rom_stb(8, ok);
            checks++; if (!ok || grant_snd !== exp_snd) $display("FAIL t3_owner_%0d got=%b exp=%b", i, grant_snd, exp_snd); else passes++;
            checks++; if (rom_addr !== (exp_snd ? snd_addr : cpu_addr)) $display("FAIL t3_addr_%0d got=%h exp=%h", i, rom_addr, exp_snd ? snd_addr : cpu_addr); else passes++;
            d = $urandom;
            rom_ack = 1'b1; rom_data = d;
            @(negedge clk);
            rom_ack = 1'b0;
            checks++; if ({cpu_ack, snd_ack} !== (exp_snd ? 2'b01 : 2'b10) || (exp_snd ? snd_data : cpu_data) !== d) $display("FAIL t3_ack_%0d got=%b/%h exp=%b/%h", i, {cpu_ack, snd_ack}, exp_snd ? snd_data : cpu_data, exp_snd ? 2'b01 : 2'b10, d); else passes++;
            $display("xfer %s grant=%0d data=%h", exp_snd ? "snd" : "cpu", i, d);
        end
        cpu_stb = 1'b0;
        snd_stb = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        logic [DATA_W-1:0] d;
        do_reset();
        cpu_addr = ADDR_W'($urandom);
        cpu_stb  = 1'b1;
        wait_rom_stb(8, ok);
        cnt = 1;
        while (ok && cnt < TMO_CYC + 50) begin
            @(negedge clk);
            if (rom_stb !== 1'b1) break;
            cnt++;
        end
        checks++; if (cnt != TMO_CYC) $display("FAIL t4_grant_cycles got=%0d exp=%0d", cnt, TMO_CYC); else passes++;
        checks++; if ({cpu_err, cpu_ack, snd_err, snd_ack} !== 4'b1000) $display("FAIL t4_err got=%b exp=1000", {cpu_err, cpu_ack, snd_err, snd_ack}); else passes++;
        $display("xfer cpu addr=%h timed out after %0d cycles", cpu_addr, cnt);
        cpu_stb = 1'b0;
        @(negedge clk);
        checks++; if ({cpu_err, rom_stb} !== 2'b00) $display("FAIL t4_err_pulse got=%b exp=00", {cpu_err, rom_stb}); else passes++;
        cpu_addr = ADDR_W'($urandom);
        cpu_stb  = 1'b1;
        @(negedge clk);
        checks++; if (rom_stb !== 1'b0) $display("FAIL t4_abort_len got=%b exp=0", rom_stb); else passes++;
        @(negedge clk);
        checks++; if (rom_stb !== 1'b1 || rom_addr !== cpu_addr) $display("FAIL t4_regrant got=%b/%h exp=1/%h", rom_stb, rom_addr, cpu_addr); else passes++;
        d = $urandom;
        rom_ack = 1'b1; rom_data = d;
        @(negedge clk);
        rom_ack = 1'b0;
        checks++; if (cpu_ack !== 1'b1 || cpu_data !== d) $display("FAIL t4_recover got=%b/%h exp=1/%h", cpu_ack, cpu_data, d); else passes++;
        $display("xfer cpu addr=%h data=%h", cpu_addr, cpu_data);
        cpu_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ack_on_timeout();
        bit ok;
        logic [DATA_W-1:0] d;
        do_reset();
        cpu_addr = ADDR_W'($urandom);
        cpu_stb  = 1'b1;
        wait_rom_stb(8, ok);
        for (int c = 1; c < TMO_CYC; c++) @(negedge clk);
        checks++; if (!ok || rom_stb !== 1'b1) $display("FAIL t5_last_cycle got=%b exp=1", rom_stb); else passes++;
        d = $urandom;
        rom_ack = 1'b1; rom_data = d;
        @(negedge clk);
        rom_ack = 1'b0; rom_data = $urandom;
        checks++; if ({cpu_ack, cpu_err} !== 2'b10 || cpu_data !== d) $display("FAIL t5_ack_wins got=%b/%h exp=10/%h", {cpu_ack, cpu_err}, cpu_data, d); else passes++;
        $display("xfer cpu addr=%h data=%h acked on timeout cycle", cpu_addr, cpu_data);
        cpu_stb = 1'b0;
        @(negedge clk);
        checks++; if ({cpu_ack, cpu_err} !== 2'b00) $display("FAIL t5_no_late_err got=%b exp=00", {cpu_ack, cpu_err}); else passes++;
        rom_ack = 1'b1; rom_data = ~d;
        @(negedge clk);
        rom_ack = 1'b0;
        checks++; if ({cpu_ack, snd_ack, rom_stb} !== 3'b000 || cpu_data !== d) $display("FAIL t5_stray_ack got=%b/%h exp=000/%h", {cpu_ack, snd_ack, rom_stb}, cpu_data, d); else passes++;
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        logic [DATA_W-1:0] d;
        do_reset();
        snd_addr = ADDR_W'($urandom);
        snd_stb  = 1'b1;
        wait_rom_stb(8, ok);
        d = $urandom | 32'h1;
        rom_ack = 1'b1; rom_data = d;
        @(negedge clk);
        rom_ack = 1'b0;
        snd_stb = 1'b0;
        checks++; if (!ok || snd_data !== d) $display("FAIL t6_setup got=%h exp=%h", snd_data, d); else passes++;
        @(negedge clk);
        snd_addr = ADDR_W'($urandom) | 22'h1;
        snd_stb  = 1'b1;
        wait_rom_stb(8, ok);
        checks++; if (!ok || grant_snd !== 1'b1) $display("FAIL t6_granted got=%b exp=1", grant_snd); else passes++;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if ({rom_stb, grant_snd, snd_ack, snd_err} !== 4'b0) $display("FAIL t6_async_clear got=%b exp=0000", {rom_stb, grant_snd, snd_ack, snd_err}); else passes++;
        checks++; if (rom_addr !== '0 || snd_data !== '0) $display("FAIL t6_regs_clear got=%h/%h exp=0/0", rom_addr, snd_data); else passes++;
        snd_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rom_ack = 1'b1; rom_data = $urandom;
        @(negedge clk);
        rom_ack = 1'b0;
        checks++; if ({snd_ack, cpu_ack, rom_stb} !== 3'b000 || snd_data !== '0) $display("FAIL t6_no_ack got=%b/%h exp=000/0", {snd_ack, cpu_ack, rom_stb}, snd_data); else passes++;
        cpu_addr = ADDR_W'($urandom);
        cpu_stb  = 1'b1;
        wait_rom_stb(8, ok);
        checks++; if (!ok || rom_addr !== cpu_addr || grant_snd !== 1'b0) $display("FAIL t6_after_release got=%h exp=%h", rom_addr, cpu_addr); else passes++;
        rom_ack = 1'b1; rom_data = $urandom;
        @(negedge clk);
        rom_ack = 1'b0;
        cpu_stb = 1'b0;
        $display("reset mid-grant: snd transfer dropped, cpu addr=%h data=%h", cpu_addr, cpu_data);
        @(negedge clk);
    endtask

    // Requesters and reader driven at random; expectations come from the arbitration rules.
    task automatic test_random();
        int   starve_m;
        bit   prev_stb;
        bit   rd_active;
        int   rd_cnt;
        int   exp_ack_cyc;
        bit   xfer_snd;
        logic [ADDR_W-1:0] xfer_addr;
        logic [DATA_W-1:0] m_cpu_data, m_snd_data;
        bit   exp_cpu_ack, exp_snd_ack, exp_own_snd;
        int   n_xfer;
        do_reset();
        starve_m = 0; prev_stb = 1'b0; rd_active = 1'b0; rd_cnt = 0;
        exp_ack_cyc = -10; xfer_snd = 1'b0; xfer_addr = '0;
        m_cpu_data = '0; m_snd_data = '0; n_xfer = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_cpu_ack = (cyc == exp_ack_cyc) && !xfer_snd;
            exp_snd_ack = (cyc == exp_ack_cyc) && xfer_snd;
            checks++; if ({cpu_ack, snd_ack, cpu_err, snd_err} !== {exp_cpu_ack, exp_snd_ack, 2'b00}) $display("FAIL rand_completion cyc=%0d got=%b exp=%b", cyc, {cpu_ack, snd_ack, cpu_err, snd_err}, {exp_cpu_ack, exp_snd_ack, 2'b00}); else passes++;
            if (exp_cpu_ack) m_cpu_data = rom_word(xfer_addr);
            if (exp_snd_ack) m_snd_data = rom_word(xfer_addr);
            if (exp_cpu_ack || exp_snd_ack) begin
                n_xfer++;
                $display("xfer %s addr=%h data=%h", xfer_snd ? "snd" : "cpu", xfer_addr, xfer_snd ? snd_data : cpu_data);
            end
            checks++; if (cpu_data !== m_cpu_data || snd_data !== m_snd_data) $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", cyc, cpu_data, snd_data, m_cpu_data, m_snd_data); else passes++;

            if (rom_stb === 1'b1 && !prev_stb) begin
                exp_own_snd = snd_stb && (!cpu_stb || starve_m == STARVE_MAX);
                checks++; if (grant_snd !== exp_own_snd) $display("FAIL rand_owner cyc=%0d got=%b exp=%b", cyc, grant_snd, exp_own_snd); else passes++;
                xfer_snd  = exp_own_snd;
                xfer_addr = exp_own_snd ? snd_addr : cpu_addr;
                checks++; if (rom_addr !== xfer_addr) $display("FAIL rand_rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, xfer_addr); else passes++;
                if (exp_own_snd) starve_m = 0;
                else if (!snd_stb) starve_m = 0;
                else if (starve_m < STARVE_MAX) starve_m++;
                rd_active = 1'b1;
                rd_cnt    = $urandom_range(0, 4);
            end
            prev_stb = (rom_stb === 1'b1);

            if (cpu_ack === 1'b1 || cpu_err === 1'b1) cpu_stb = 1'b0;
            else if (!cpu_stb && $urandom_range(0, 3) == 0) begin
                cpu_addr = ADDR_W'($urandom);
                cpu_stb  = 1'b1;
            end
            if (snd_ack === 1'b1 || snd_err === 1'b1) snd_stb = 1'b0;
            else if (!snd_stb && $urandom_range(0, 5) == 0) begin
                snd_addr = ADDR_W'($urandom);
                snd_stb  = 1'b1;
            end

            rom_ack  = 1'b0;
            rom_data = $urandom;
            if (rd_active) begin
                checks++; if (rom_stb !== 1'b1) $display("FAIL rand_stb_held cyc=%0d got=%b exp=1", cyc, rom_stb); else passes++;
                if (rd_cnt == 0) begin
                    rom_ack     = 1'b1;
                    rom_data    = rom_word(rom_addr);
                    exp_ack_cyc = cyc + 1;
                    rd_active   = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if (rom_stb === 1'b0 && $urandom_range(0, 7) == 0) begin
                rom_ack = 1'b1;
            end
        end
        checks++; if (n_xfer < 100) $display("FAIL rand_throughput got=%0d exp>=100", n_xfer); else passes++;
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        test_reset();
        test_single_cpu();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
